// File: rtl/souper_aud_pkg.sv
// Shared types and constants for the Souper audio command receiver.
package souper_aud_pkg;

  typedef logic [7:0] aud_cmd_t;

  localparam int       AUD_DEF_DEPTH = 16;
  localparam aud_cmd_t AUD_OVF_MAX   = 8'hFF;

endpackage

// File: rtl/souper_aud_fifo.sv
// Synchronous FIFO with a registered show-ahead head; pointers carry one
// extra bit so that full and empty can be told apart.
module souper_aud_fifo
  import souper_aud_pkg::*;
#(
  parameter int DEPTH = AUD_DEF_DEPTH
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     push_i,
  input  aud_cmd_t                 data_i,
  input  logic                     pop_i,
  output aud_cmd_t                 head_o,
  output logic                     head_valid_o,
  output logic                     full_o,
  output logic [$clog2(DEPTH):0]   level_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;

  aud_cmd_t        mem [DEPTH];
  logic [PW-1:0]   wptr_q, wptr_d;
  logic [PW-1:0]   rptr_q, rptr_d;
  aud_cmd_t        head_q;
  logic            head_valid_q;
  logic            wr_en;
  logic            rd_en;
  logic [PW-1:0]   level;

  assign level  = wptr_q - rptr_q;
  assign full_o = (level == PW'(DEPTH));
  assign rd_en  = pop_i & head_valid_q;
  // A pop frees the slot the push lands in, so a full FIFO may still accept.
  assign wr_en  = push_i & (~full_o | rd_en);

  always_comb begin
    wptr_d = wptr_q + PW'(wr_en);
    rptr_d = rptr_q + PW'(rd_en);
  end

  always_ff @(posedge clk_i) begin
    if (wr_en) mem[wptr_q[AW-1:0]] <= data_i;
  end

  // Head compares against the old write pointer: a fresh entry shows up one
  // edge after it is written.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wptr_q       <= '0;
      rptr_q       <= '0;
      head_q       <= '0;
      head_valid_q <= 1'b0;
    end else begin
      wptr_q       <= wptr_d;
      rptr_q       <= rptr_d;
      head_q       <= mem[rptr_d[AW-1:0]];
      head_valid_q <= (rptr_d != wptr_q);
    end
  end

  assign head_o       = head_q;
  assign head_valid_o = head_valid_q;
  assign level_o      = level;

endmodule

// File: rtl/souper_aud_rx.sv
// Souper audio command receiver: request toggle synchroniser, capture FIFO and
// sticky overflow flag. Define SOUPER_AUD_OVF_CNT_EN to add the drop counter.
module souper_aud_rx
  import souper_aud_pkg::*;
#(
  parameter int DEPTH = AUD_DEF_DEPTH
) (
  input  logic                   clk_sys,
  input  logic                   reset,
  input  aud_cmd_t               aud_com,
  input  logic                   aud_req_n,
  output aud_cmd_t               cmd_data,
  output logic                   cmd_valid,
  input  logic                   cmd_ready,
  output logic [$clog2(DEPTH):0] level,
  output logic                   ovf,
`ifdef SOUPER_AUD_OVF_CNT_EN
  output logic [7:0]             ovf_cnt,
`endif
  input  logic                   ovf_clr
);

  logic req_s1_q, req_s2_q, req_s3_q;
  logic push, pop, full, drop;
  logic ovf_q, ovf_d;

  // Flops idle high to match the released request line.
  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      req_s1_q <= 1'b1;
      req_s2_q <= 1'b1;
      req_s3_q <= 1'b1;
    end else begin
      req_s1_q <= aud_req_n;
      req_s2_q <= req_s1_q;
      req_s3_q <= req_s2_q;
    end
  end

  assign push = req_s2_q ^ req_s3_q;
  assign pop  = cmd_valid & cmd_ready;
  assign drop = push & full & ~pop;

  // aud_com is sampled raw: it has been stable for two cycles by now.
  souper_aud_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk_i        (clk_sys),
    .rst_i        (reset),
    .push_i       (push),
    .data_i       (aud_com),
    .pop_i        (pop),
    .head_o       (cmd_data),
    .head_valid_o (cmd_valid),
    .full_o       (full),
    .level_o      (level)
  );

  always_comb begin
    ovf_d = ovf_q;
    if (drop)         ovf_d = 1'b1;
    else if (ovf_clr) ovf_d = 1'b0;
  end

  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) ovf_q <= 1'b0;
    else       ovf_q <= ovf_d;
  end

  assign ovf = ovf_q;

`ifdef SOUPER_AUD_OVF_CNT_EN
  logic [7:0] ovf_cnt_q, ovf_cnt_d;

  // A drop in the clear cycle restarts the count at one.
  always_comb begin
    ovf_cnt_d = ovf_cnt_q;
    if (drop) begin
      if (ovf_clr)                       ovf_cnt_d = 8'd1;
      else if (ovf_cnt_q != AUD_OVF_MAX) ovf_cnt_d = ovf_cnt_q + 8'd1;
    end else if (ovf_clr) begin
      ovf_cnt_d = 8'd0;
    end
  end

  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) ovf_cnt_q <= 8'd0;
    else       ovf_cnt_q <= ovf_cnt_d;
  end

  assign ovf_cnt = ovf_cnt_q;
`endif

endmodule

// File: tb/tb_souper_aud_rx.sv
// Directed bench for souper_aud_rx: reset, latency, ordering, overflow,
// full-with-pop and reset mid-burst.
module tb_souper_aud_rx;
  import souper_aud_pkg::*;

  logic       clk_sys = 1'b0;
  logic       reset;
  aud_cmd_t   aud_com;
  logic       aud_req_n;
  aud_cmd_t   cmd_data;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [4:0] level;
  logic       ovf;
  logic       ovf_clr;
`ifdef SOUPER_AUD_OVF_CNT_EN
  logic [7:0] ovf_cnt;
`endif

  int total = 0;
  int bad   = 0;

  always #5 clk_sys = ~clk_sys;

  souper_aud_rx #(.DEPTH(16)) dut (
    .clk_sys   (clk_sys),
    .reset     (reset),
    .aud_com   (aud_com),
    .aud_req_n (aud_req_n),
    .cmd_data  (cmd_data),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .level     (level),
    .ovf       (ovf),
`ifdef SOUPER_AUD_OVF_CNT_EN
    .ovf_cnt   (ovf_cnt),
`endif
    .ovf_clr   (ovf_clr)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end else begin
      $display("ok   %s: %0h", tag, got);
    end
  endtask

  task automatic tick();
    @(posedge clk_sys);
    #1;
  endtask

  // One command: set the byte, toggle the line a cycle later, 8-cycle spacing.
  task automatic send(input aud_cmd_t b);
    aud_com = b;
    tick();
    aud_req_n = ~aud_req_n;
    repeat (7) tick();
  endtask

  initial begin
    reset     = 1'b1;
    aud_com   = 8'h00;
    aud_req_n = 1'b1;
    cmd_ready = 1'b0;
    ovf_clr   = 1'b0;
    repeat (3) tick();
    check("rst_valid", 32'(cmd_valid), 32'd0);
    check("rst_data",  32'(cmd_data),  32'd0);
    check("rst_level", 32'(level),     32'd0);
    check("rst_ovf",   32'(ovf),       32'd0);
`ifdef SOUPER_AUD_OVF_CNT_EN
    check("rst_ovfcnt", 32'(ovf_cnt), 32'd0);
`endif
    reset = 1'b0;
    repeat (50) tick();
    check("idle_valid", 32'(cmd_valid), 32'd0);
    check("idle_level", 32'(level),     32'd0);

    // Single command latency: valid on the 4th edge after the toggle.
    cmd_ready = 1'b1;
    aud_com   = 8'hA5;
    tick();
    aud_req_n = 1'b0;
    repeat (3) tick();
    check("single_valid_e3", 32'(cmd_valid), 32'd0);
    tick();
    check("single_valid_e4", 32'(cmd_valid), 32'd1);
    check("single_data",     32'(cmd_data),  32'hA5);
    tick();
    check("single_popped", 32'(cmd_valid), 32'd0);
    check("single_level",  32'(level),     32'd0);

    // Burst of 16, then drain in order at one per cycle.
    cmd_ready = 1'b0;
    for (int i = 0; i < 16; i++) send(8'(i));
    check("burst_level", 32'(level), 32'd16);
    check("burst_ovf",   32'(ovf),   32'd0);
    cmd_ready = 1'b1;
    for (int i = 0; i < 16; i++) begin
      check($sformatf("drain_data[%0d]", i), 32'(cmd_data), 32'(i));
      tick();
    end
    check("drain_valid", 32'(cmd_valid), 32'd0);
    check("drain_level", 32'(level),     32'd0);

    // Refill to full, then three dropped commands.
    cmd_ready = 1'b0;
    for (int i = 0; i < 16; i++) send(8'(8'h10 + i));
    send(8'hAA);
    send(8'hBB);
    send(8'hCC);
    check("ovf_level", 32'(level),    32'd16);
    check("ovf_head",  32'(cmd_data), 32'h10);
    check("ovf_flag",  32'(ovf),      32'd1);
`ifdef SOUPER_AUD_OVF_CNT_EN
    check("ovf_cnt3", 32'(ovf_cnt), 32'd3);
`endif
    ovf_clr = 1'b1;
    tick();
    ovf_clr = 1'b0;
    check("ovf_clr_flag", 32'(ovf), 32'd0);
`ifdef SOUPER_AUD_OVF_CNT_EN
    check("ovf_clr_cnt", 32'(ovf_cnt), 32'd0);
`endif

    // Full with pop on the push cycle: nothing dropped, new byte goes last.
    aud_com = 8'h77;
    tick();
    aud_req_n = ~aud_req_n;
    repeat (2) tick();
    cmd_ready = 1'b1;
    tick();
    cmd_ready = 1'b0;
    check("fullpop_level", 32'(level), 32'd16);
    check("fullpop_ovf",   32'(ovf),   32'd0);
    repeat (4) tick();
    cmd_ready = 1'b1;
    for (int i = 1; i < 16; i++) begin
      check($sformatf("fullpop_data[%0d]", i), 32'(cmd_data), 32'(8'h10 + i));
      tick();
    end
    check("fullpop_last", 32'(cmd_data), 32'h77);
    tick();
    check("fullpop_empty", 32'(cmd_valid), 32'd0);

    // Reset mid-burst discards queued commands.
    cmd_ready = 1'b0;
    for (int i = 0; i < 5; i++) send(8'(8'h50 + i));
    check("mid_level5", 32'(level), 32'd5);
    reset     = 1'b1;
    aud_req_n = 1'b1;
    tick();
    check("mid_rst_level", 32'(level),     32'd0);
    check("mid_rst_valid", 32'(cmd_valid), 32'd0);
    reset = 1'b0;
    repeat (4) tick();
    check("mid_no_spurious", 32'(level), 32'd0);
    send(8'h3C);
    check("mid_after_level", 32'(level),    32'd1);
    check("mid_after_data",  32'(cmd_data), 32'h3C);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
